// File: rtl/lfsr_stream_cipher.sv
// LFSR stream-cipher engine sharing the processor's data-memory port: encrypts a
// pad-framed message, or recovers seed, taps, pre-length and message from a frame.
module lfsr_stream_cipher #(
  parameter int W         = 8,
  parameter int ADDR_W    = 8,
  parameter int MSG_LEN   = 41,
  parameter int FRAME_LEN = 64,
  parameter int MSG_BASE  = 0,
  parameter int CFG_BASE  = 41,
  parameter int OUT_BASE  = 64,
  parameter int TAP_BASE  = 140,
  parameter int NUM_TAPS  = 8,
  parameter int CHECK_LEN = 8,
  parameter logic [W-1:0] PAD = 8'h20
) (
  input  logic              clk_i,
  input  logic              init_i,
  input  logic              start_i,
  input  logic              mode_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [W-1:0]      mem_rd_data_i,
  output logic              mem_wr_en_o,
  output logic [W-1:0]      mem_wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int PRE_MAX = FRAME_LEN - MSG_LEN;
  localparam int IDX_W   = $clog2(FRAME_LEN + 1);
  localparam int TAP_W   = $clog2(NUM_TAPS + 1);

  typedef enum logic [3:0] {
    IDLE, CFG_RD, ENC_RUN, DEC_SEED, TAP_RD, TAP_CHK, DEC_SCAN, DEC_WR, CFG_WR, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic             phase_q, phase_d;
  logic [W-1:0]     lfsr_q, lfsr_d;
  logic [W-1:0]     seed_q, seed_d;
  logic [W-1:0]     ptrn_q, ptrn_d;
  logic [W-1:0]     pre_q, pre_d;
  logic             err_q, err_d;

  int           idxInt, preInt, tapInt;
  logic         isMsg;
  logic [W-1:0] lfsrNext, decByte;

  function automatic logic [W-1:0] lfsrStep(input logic [W-1:0] s, input logic [W-1:0] p);
    return {s[W-2:0], ^(s & p)};
  endfunction

  function automatic logic [ADDR_W-1:0] addrOf(input int base, input int offs);
    return ADDR_W'(base + offs);
  endfunction

  assign idxInt   = int'(idx_q);
  assign preInt   = int'(pre_q);
  assign tapInt   = int'(tap_q);
  assign isMsg    = (idxInt >= preInt) && (idxInt < preInt + MSG_LEN);
  assign lfsrNext = lfsrStep(lfsr_q, ptrn_q);
  assign decByte  = mem_rd_data_i ^ lfsr_q;

  assign busy_o = (state_q != IDLE) && (state_q != DONE);
  assign done_o = (state_q == DONE);
  assign err_o  = err_q;

  always_ff @(posedge clk_i) begin
    if (init_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tap_q   <= '0;
      phase_q <= 1'b0;
      lfsr_q  <= '0;
      seed_q  <= '0;
      ptrn_q  <= '0;
      pre_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tap_q   <= tap_d;
      phase_q <= phase_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      ptrn_q  <= ptrn_d;
      pre_q   <= pre_d;
      err_q   <= err_d;
    end
  end

  // Every memory byte takes a read phase (address out) and a use phase (data back).
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tap_d         = tap_q;
    phase_d       = phase_q;
    lfsr_d        = lfsr_q;
    seed_d        = seed_q;
    ptrn_d        = ptrn_q;
    pre_d         = pre_q;
    err_d         = err_q;
    mem_addr_o    = '0;
    mem_wr_en_o   = 1'b0;
    mem_wr_data_o = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          err_d   = 1'b0;
          idx_d   = '0;
          tap_d   = '0;
          phase_d = 1'b0;
          state_d = mode_i ? DEC_SEED : CFG_RD;
        end
      end

      CFG_RD: begin
        mem_addr_o = addrOf(CFG_BASE, idxInt);
        idx_d      = idx_q + IDX_W'(1);
        if (idxInt == 1) begin
          pre_d = (int'(mem_rd_data_i) > PRE_MAX) ? W'(PRE_MAX) : mem_rd_data_i;
        end else if (idxInt == 2) begin
          ptrn_d = mem_rd_data_i;
        end else if (idxInt == 3) begin
          seed_d  = mem_rd_data_i;
          lfsr_d  = mem_rd_data_i;
          idx_d   = '0;
          phase_d = 1'b0;
          state_d = ENC_RUN;
        end
      end

      ENC_RUN: begin
        if (!phase_q) begin
          if (isMsg) mem_addr_o = addrOf(MSG_BASE, idxInt - preInt);
          phase_d = 1'b1;
        end else begin
          mem_addr_o    = addrOf(OUT_BASE, idxInt);
          mem_wr_en_o   = 1'b1;
          mem_wr_data_o = (isMsg ? mem_rd_data_i : PAD) ^ lfsr_q;
          lfsr_d        = lfsrNext;
          phase_d       = 1'b0;
          if (idxInt == FRAME_LEN - 1) state_d = DONE;
          else idx_d = idx_q + IDX_W'(1);
        end
      end

      DEC_SEED: begin
        mem_addr_o = addrOf(OUT_BASE, 0);
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          seed_d  = mem_rd_data_i ^ PAD;
          tap_d   = '0;
          phase_d = 1'b0;
          state_d = TAP_RD;
        end
      end

      TAP_RD: begin
        mem_addr_o = addrOf(TAP_BASE, tapInt);
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          ptrn_d  = mem_rd_data_i;
          lfsr_d  = lfsrStep(seed_q, mem_rd_data_i);
          idx_d   = IDX_W'(1);
          phase_d = 1'b0;
          state_d = TAP_CHK;
        end
      end

      // Frame byte 0 fixed the seed, so the candidate is judged on bytes 1..CHECK_LEN.
      TAP_CHK: begin
        mem_addr_o = addrOf(OUT_BASE, idxInt);
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (decByte != PAD) begin
            if (tapInt == NUM_TAPS - 1) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              tap_d   = tap_q + TAP_W'(1);
              state_d = TAP_RD;
            end
          end else if (idxInt == CHECK_LEN) begin
            lfsr_d  = seed_q;
            idx_d   = '0;
            pre_d   = '0;
            state_d = DEC_SCAN;
          end else begin
            lfsr_d = lfsrNext;
            idx_d  = idx_q + IDX_W'(1);
          end
        end
      end

      DEC_SCAN: begin
        mem_addr_o = addrOf(OUT_BASE, idxInt);
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if ((decByte == PAD) && (preInt < PRE_MAX)) begin
            pre_d  = pre_q + W'(1);
            lfsr_d = lfsrNext;
            idx_d  = idx_q + IDX_W'(1);
          end else begin
            lfsr_d  = seed_q;
            idx_d   = '0;
            state_d = DEC_WR;
          end
        end
      end

      // Advance the keystream over the preamble without touching memory, then copy.
      DEC_WR: begin
        if (idxInt < preInt) begin
          lfsr_d = lfsrNext;
          idx_d  = idx_q + IDX_W'(1);
        end else if (!phase_q) begin
          mem_addr_o = addrOf(OUT_BASE, idxInt);
          phase_d    = 1'b1;
        end else begin
          mem_addr_o    = addrOf(MSG_BASE, idxInt - preInt);
          mem_wr_en_o   = 1'b1;
          mem_wr_data_o = decByte;
          lfsr_d        = lfsrNext;
          phase_d       = 1'b0;
          if (idxInt == preInt + MSG_LEN - 1) begin
            idx_d   = '0;
            state_d = CFG_WR;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      CFG_WR: begin
        mem_addr_o    = addrOf(CFG_BASE, idxInt);
        mem_wr_en_o   = 1'b1;
        mem_wr_data_o = (idxInt == 0) ? pre_q : (idxInt == 1) ? ptrn_q : seed_q;
        if (idxInt == 2) state_d = DONE;
        else idx_d = idx_q + IDX_W'(1);
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
